// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues pipelined imem fetches and queues returned words for decode.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, twr_q, twr_d, trd_q, trd_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   instr_d [FIFO_DEPTH];
  logic [31:0]   qpc_q   [FIFO_DEPTH];
  logic [31:0]   qpc_d   [FIFO_DEPTH];
  logic [31:0]   tag_q   [FIFO_DEPTH];
  logic [31:0]   tag_d   [FIFO_DEPTH];

  logic          empty, pop, push, grant, rvalid_ok;
  logic [SW-1:0] used;

  assign empty     = (cnt_q == '0);
  assign id_valid  = rst_n && !empty;
  assign pop       = id_valid && !stall;
  assign rvalid_ok = imem_rvalid && (out_q != '0);
  assign push      = rvalid_ok && (disc_q == '0) && !redirect;
  assign grant     = imem_req && imem_gnt;

  // A word popped this cycle frees its slot, which keeps one fetch per cycle in flight.
  assign used      = SW'(out_q) + SW'(disc_q) + SW'(cnt_q) - SW'(pop);
  assign imem_req  = rst_n && !redirect && (used < SW'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign id_instr  = empty ? 32'h0 : instr_q[rd_q];
  assign id_pc     = empty ? 32'h0 : qpc_q[rd_q];

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q + CW'(grant) - CW'(rvalid_ok);
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    twr_d   = twr_q;
    trd_d   = trd_q;
    instr_d = instr_q;
    qpc_d   = qpc_q;
    tag_d   = tag_q;

    if (grant) begin
      pc_d         = pc_q + 32'd4;
      tag_d[twr_q] = pc_q;
      twr_d        = twr_q + 1'b1;
    end
    if (rvalid_ok) begin
      trd_d = trd_q + 1'b1;
    end

    if (redirect) begin
      // Every request still in flight now returns a stale word that must be dropped.
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      disc_d = out_q - CW'(rvalid_ok);
      cnt_d  = '0;
      rd_d   = wr_q;
    end else begin
      if (rvalid_ok && disc_q != '0) begin
        disc_d = disc_q - 1'b1;
      end
      if (push) begin
        instr_d[wr_q] = imem_rdata;
        qpc_d[wr_q]   = tag_q[trd_q];
        wr_d          = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      twr_q  <= '0;
      trd_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        qpc_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
      instr_q <= instr_d;
      qpc_q   <= qpc_d;
      tag_q   <= tag_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'(id_valid && stall);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
